// File: rtl/fetch_queue16_if.sv
// Fetch-stage buses: program-memory read port and the bundle handshake toward decode.
// master = fetch queue side, slave = memory/decode environment side.
interface fetch_queue16_if #(
    parameter int WORD_WIDTH = 16
);
    logic                      imem_req;
    logic [WORD_WIDTH-1:0]     imem_addr;
    logic [4*WORD_WIDTH-1:0]   imem_rdata;
    logic                      instr_valid;
    logic                      instr_ready;
    logic [4*WORD_WIDTH-1:0]   instr_data;
    logic [WORD_WIDTH-1:0]     instr_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_queue16.sv
// Fetch/prefetch queue: issues PC-stepped reads, buffers {dest,arg2,arg1,opcode} bundles; req->valid 2 cycles.
// Backpressure: issue stops while buffered+in-flight reaches DEPTH; head held while instr_ready is low.
module fetch_queue16 #(
    parameter int                    WORD_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter int                    PC_STEP    = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    fetch_queue16_if.master               bus,
    input  logic                          redirect_en,
    input  logic [WORD_WIDTH-1:0]         redirect_pc,
    input  logic                          halt,
    output logic                          halted,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [CNT_W:0]        DEPTH_L = DEPTH[CNT_W:0];
    localparam logic [WORD_WIDTH-1:0] STEP_L  = PC_STEP[WORD_WIDTH-1:0];
    localparam logic [PTR_W-1:0]      PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [WORD_WIDTH-1:0] dest;
        logic [WORD_WIDTH-1:0] arg2;
        logic [WORD_WIDTH-1:0] arg1;
        logic [WORD_WIDTH-1:0] opcode;
    } bundle_t;

    logic [0:0]            state_q, state_d;
    logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [WORD_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    bundle_t               data_q [DEPTH];
    bundle_t               data_d [DEPTH];
    logic [WORD_WIDTH-1:0] pc_q   [DEPTH];
    logic [WORD_WIDTH-1:0] pc_d   [DEPTH];

    logic           running;
    logic           do_redirect;
    logic           do_issue;
    logic           do_enq;
    logic           do_deq;
    logic           head_vld;
    logic [CNT_W:0] occupancy;

    always_comb begin
        running     = (state_q == ST_RUN);
        do_redirect = running & redirect_en;
        head_vld    = (count_q != '0);
        // Credits cover both stored and in-flight bundles, so a capture can never overflow.
        occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        do_issue    = ~rst & running & ~halt & ~redirect_en & (occupancy < DEPTH_L);
        do_enq      = inflight_q & ~do_redirect;
        do_deq      = head_vld & bus.instr_ready;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = do_issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        data_d        = data_q;
        pc_d          = pc_q;

        if (running && halt && !redirect_en) begin
            state_d = ST_HALTED;
        end

        if (do_issue) begin
            fetch_pc_d    = fetch_pc_q + STEP_L;
            inflight_pc_d = fetch_pc_q;
        end

        if (do_enq) begin
            data_d[wr_ptr_q] = bundle_t'(bus.imem_rdata);
            pc_d[wr_ptr_q]   = inflight_pc_q;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (do_deq) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A same-cycle dequeue still completes; everything else, including the in-flight read, is dropped.
        if (do_redirect) begin
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            data_q        <= data_d;
            pc_q          <= pc_d;
        end
    end

    assign bus.imem_req    = do_issue;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = head_vld;
    assign bus.instr_data  = head_vld ? data_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = head_vld ? pc_q[rd_ptr_q] : '0;
    assign halted          = (state_q == ST_HALTED);
    assign count           = count_q;
endmodule

// File: tb/tb_fetch_queue16.sv
// Randomized bench for fetch_queue16: queue-based reference of issued-but-unconsumed PCs plus a dequeue monitor.
module tb_fetch_queue16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue16_if #(.WORD_WIDTH(16)) bus ();

    fetch_queue16 #(
        .WORD_WIDTH (16),
        .DEPTH      (DEPTH),
        .PC_STEP    (4),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted),
        .count       (count)
    );

    int checks = 0;
    int errors = 0;
    int delivered = 0;

    // Scoreboard: PCs issued to memory and not yet consumed or flushed, oldest first.
    logic [15:0] exp_q[$];
    logic [15:0] model_pc = 16'h0000;
    bit          model_halted = 1'b0;
    bit          last_issue = 1'b0;
    bit          rst_prev = 1'b0;

    function automatic logic [63:0] tag(input logic [15:0] pc);
        return {pc ^ 16'h5A5A, pc + 16'h0003, ~pc, pc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program memory: returns an address-tagged bundle one cycle after each request, garbage otherwise.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? tag(bus.imem_addr) : {$urandom, $urandom};
    end

    // Reference model: checks issue/occupancy each cycle and records what should later be delivered.
    always @(negedge clk) begin
        int exp_count;
        bit exp_req;
        bit exp_deq;
        if (rst) begin
            if (rst_prev) begin
                check("rst_imem_req", 64'(bus.imem_req), 64'(0));
                check("rst_count", 64'(count), 64'(0));
                check("rst_instr_valid", 64'(bus.instr_valid), 64'(0));
                check("rst_instr_data", bus.instr_data, 64'(0));
                check("rst_instr_pc", 64'(bus.instr_pc), 64'(0));
                check("rst_halted", 64'(halted), 64'(0));
            end
            exp_q.delete();
            model_pc     = 16'h0000;
            model_halted = 1'b0;
            last_issue   = 1'b0;
        end else begin
            exp_req   = !model_halted && !halt && !redirect_en && (exp_q.size() < DEPTH);
            exp_count = exp_q.size() - int'(last_issue);
            check("imem_req", 64'(bus.imem_req), 64'(exp_req));
            if (exp_req && bus.imem_req) check("imem_addr", 64'(bus.imem_addr), 64'(model_pc));
            check("count", 64'(count), 64'(exp_count));
            check("instr_valid", 64'(bus.instr_valid), 64'(exp_count != 0));
            check("halted", 64'(halted), 64'(model_halted));
            exp_deq = (exp_count != 0) && bus.instr_ready;
            if (redirect_en && !model_halted) begin
                if (exp_deq) begin
                    while (exp_q.size() > 1) void'(exp_q.pop_back());
                end else begin
                    exp_q.delete();
                end
                model_pc   = redirect_pc;
                last_issue = 1'b0;
            end else begin
                if (exp_req) begin
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 16'd4;
                end
                last_issue = exp_req;
                if (halt) model_halted = 1'b1;
            end
        end
        rst_prev = rst;
    end

    // Monitor: every accepted bundle must be the oldest expected PC with its tagged data.
    always @(negedge clk) begin
        logic [15:0] pc;
        #1;
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got pc %h expected none at %0t", bus.instr_pc, $time);
            end else begin
                pc = exp_q.pop_front();
                check("instr_pc", 64'(bus.instr_pc), 64'(pc));
                check("instr_data", bus.instr_data, tag(pc));
                delivered++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        redirect_en     = 1'b0;
        redirect_pc     = 16'h0000;
        halt            = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        cyc(20);
        bus.instr_ready = 1'b0; cyc(8);
        bus.instr_ready = 1'b1; cyc(1);
        bus.instr_ready = 1'b0; cyc(4);
        bus.instr_ready = 1'b1; cyc(6);

        bus.instr_ready = 1'b0; cyc(3);
        redirect_en = 1'b1; redirect_pc = 16'h0100; cyc(1);
        redirect_en = 1'b0; bus.instr_ready = 1'b1; cyc(8);

        redirect_en = 1'b1; redirect_pc = 16'hFFF0; cyc(1);
        redirect_en = 1'b0; cyc(10);

        halt = 1'b1; redirect_en = 1'b1; redirect_pc = 16'h0200; cyc(1);
        halt = 1'b0; redirect_en = 1'b0; cyc(6);

        for (int i = 0; i < 1500; i++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            redirect_en     = ($urandom_range(0, 15) == 0);
            redirect_pc     = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'($urandom);
            cyc(1);
        end
        redirect_en = 1'b0;

        // Halt with two buffered and one in flight, then drain; the later redirect must be ignored.
        bus.instr_ready = 1'b0;
        redirect_en = 1'b1; redirect_pc = 16'h0040; cyc(1);
        redirect_en = 1'b0; cyc(3);
        halt = 1'b1; cyc(1);
        halt = 1'b0; cyc(3);
        bus.instr_ready = 1'b1; cyc(8);
        redirect_en = 1'b1; redirect_pc = 16'h0300; cyc(1);
        redirect_en = 1'b0; cyc(4);

        rst = 1'b1; cyc(2);
        rst = 1'b0; cyc(12);

        check("progress", 64'(delivered > 200), 64'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
